// File: rtl/gpu_frame_reader.sv
// Snapshots the vector core's RGB lanes on capture and streams them out as
// 8-bit pixels, one lane per handshake, so the core can run on meanwhile.
module gpu_frame_reader #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [LANES*WORD_SIZE*3-1:0]     i_frame_in,
  input  logic                             i_capture,
  output logic                             o_busy,
  output logic                             o_pix_valid,
  input  logic                             i_pix_ready,
  output logic [$clog2(LANES)-1:0]         o_pix_index,
  output logic [7:0]                       o_pix_r,
  output logic [7:0]                       o_pix_g,
  output logic [7:0]                       o_pix_b,
  output logic                             o_frame_done,
  output logic [7:0]                       o_dropped
);

  localparam int unsigned LANE_W = 3 * WORD_SIZE;
  localparam int unsigned IDX_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM
  } state_t;

  state_t                r_state;
  logic [LANE_W-1:0]     r_shadow [LANES];
  logic                  r_busy;
  logic                  r_pix_valid;
  logic [IDX_W-1:0]      r_pix_index;
  logic [7:0]            r_pix_r;
  logic [7:0]            r_pix_g;
  logic [7:0]            r_pix_b;
  logic                  r_frame_done;
  logic [7:0]            r_dropped;

  logic [IDX_W-1:0]      w_sel;
  logic [LANE_W-1:0]     w_lane;
  logic [7:0]            w_r;
  logic [7:0]            w_g;
  logic [7:0]            w_b;
  logic                  w_accept;
  logic                  w_last;

  // Non-negative finite fp16 below 1.0 becomes floor(value*256); everything else clamps.
  function automatic logic [7:0] f_fp16_to_u8(input logic [15:0] h);
    logic [4:0]  e;
    logic [10:0] mant;
    e    = h[14:10];
    mant = {1'b1, h[9:0]};
    if (h[15] || (e == 5'd0)) return 8'd0;
    else if (e >= 5'd15)      return 8'hFF;
    else                      return 8'(mant >> (5'd17 - e));
  endfunction

  // LOAD presents lane 0; each accepted beat in STREAM prepares the following lane.
  assign w_sel    = (r_state == S_LOAD) ? '0 : r_pix_index + IDX_W'(1);
  assign w_lane   = r_shadow[w_sel];
  assign w_r      = f_fp16_to_u8(w_lane[0 +: 16]);
  assign w_g      = f_fp16_to_u8(w_lane[16 +: 16]);
  assign w_b      = f_fp16_to_u8(w_lane[32 +: 16]);
  assign w_accept = r_pix_valid && i_pix_ready;
  assign w_last   = (r_pix_index == IDX_W'(LANES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_index  <= '0;
      r_pix_r      <= 8'd0;
      r_pix_g      <= 8'd0;
      r_pix_b      <= 8'd0;
      r_frame_done <= 1'b0;
      r_dropped    <= 8'd0;
      for (int i = 0; i < int'(LANES); i++) r_shadow[i] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if ((r_state != S_IDLE) && i_capture && (r_dropped != 8'hFF))
        r_dropped <= r_dropped + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (i_capture) begin
            for (int i = 0; i < int'(LANES); i++)
              r_shadow[i] <= i_frame_in[i*LANE_W +: LANE_W];
            r_pix_index <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_pix_r     <= w_r;
          r_pix_g     <= w_g;
          r_pix_b     <= w_b;
          r_pix_index <= '0;
          r_pix_valid <= 1'b1;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          if (w_accept) begin
            if (!w_last) begin
              r_pix_r     <= w_r;
              r_pix_g     <= w_g;
              r_pix_b     <= w_b;
              r_pix_index <= w_sel;
            end else begin
              r_pix_valid  <= 1'b0;
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_index  = r_pix_index;
  assign o_pix_r      = r_pix_r;
  assign o_pix_g      = r_pix_g;
  assign o_pix_b      = r_pix_b;
  assign o_frame_done = r_frame_done;
  assign o_dropped    = r_dropped;

endmodule

// File: tb/tb_gpu_frame_reader.sv
// Scoreboard bench for gpu_frame_reader: stimulus queues expected pixels,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_gpu_frame_reader;

  localparam int unsigned LANES = 16;
  localparam int unsigned FW    = LANES * 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          capture = 1'b0;
  logic          busy;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [3:0]    pix_index;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic          frame_done;
  logic [7:0]    dropped;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] tab_h [16];
  logic [7:0]  tab_u [16];
  logic [27:0] exp_q [$];

  logic        hold_pend = 1'b0;
  logic [28:0] hold_val  = '0;

  gpu_frame_reader #(.LANES(16), .WORD_SIZE(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_in   (frame_in),
    .i_capture    (capture),
    .o_busy       (busy),
    .o_pix_valid  (pix_valid),
    .i_pix_ready  (pix_ready),
    .o_pix_index  (pix_index),
    .o_pix_r      (pix_r),
    .o_pix_g      (pix_g),
    .o_pix_b      (pix_b),
    .o_frame_done (frame_done),
    .o_dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Hand-converted fp16 -> u8 pairs; lane i uses entries i, i+5, i+11 (plus offset).
  task automatic init_tab();
    tab_h[0]  = 16'h3800; tab_u[0]  = 8'd128;
    tab_h[1]  = 16'h3A00; tab_u[1]  = 8'd192;
    tab_h[2]  = 16'h7C00; tab_u[2]  = 8'd255;
    tab_h[3]  = 16'h0000; tab_u[3]  = 8'd0;
    tab_h[4]  = 16'h8000; tab_u[4]  = 8'd0;
    tab_h[5]  = 16'h3C00; tab_u[5]  = 8'd255;
    tab_h[6]  = 16'hB800; tab_u[6]  = 8'd0;
    tab_h[7]  = 16'h3BFF; tab_u[7]  = 8'd255;
    tab_h[8]  = 16'h2C00; tab_u[8]  = 8'd16;
    tab_h[9]  = 16'h3000; tab_u[9]  = 8'd32;
    tab_h[10] = 16'h3C01; tab_u[10] = 8'd255;
    tab_h[11] = 16'h3400; tab_u[11] = 8'd64;
    tab_h[12] = 16'h0001; tab_u[12] = 8'd0;
    tab_h[13] = 16'h0400; tab_u[13] = 8'd0;
    tab_h[14] = 16'h3555; tab_u[14] = 8'd85;
    tab_h[15] = 16'h3933; tab_u[15] = 8'd166;
  endtask

  function automatic logic [FW-1:0] mk_frame(input int off);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      f[i*48 +: 16]      = tab_h[(i + off) % 16];
      f[i*48 + 16 +: 16] = tab_h[(i + off + 5) % 16];
      f[i*48 + 32 +: 16] = tab_h[(i + off + 11) % 16];
    end
    return f;
  endfunction

  task automatic push_frame(input int off);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({4'(i), tab_u[(i + off) % 16], tab_u[(i + off + 5) % 16],
                       tab_u[(i + off + 11) % 16]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_index"}, 32'(pix_index), 32'd0);
    chk({tag, "_rgb"},   32'({pix_r, pix_g, pix_b}), 32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_drop"},  32'(dropped), 32'd0);
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int c;
    c = 0;
    while (c < max_cyc) begin
      @(posedge clk); #1;
      c++;
      if (frame_done) break;
    end
    chk(nm, 32'(frame_done), 32'd1);
  endtask

  // Monitor: scoreboard pops on handshake, and stalled outputs must hold.
  always @(negedge clk) begin
    logic [27:0] e;
    if (rst_n) begin
      if (hold_pend) begin
        n_vec++;
        if ({pix_valid, pix_index, pix_r, pix_g, pix_b} !== hold_val) begin
          n_err++;
          $display("FAIL stall_hold: got %h want %h",
                   {pix_valid, pix_index, pix_r, pix_g, pix_b}, hold_val);
        end
      end
      hold_pend = 1'b0;
      if (pix_valid && pix_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pixel_unexpected: got %h want none", {pix_index, pix_r, pix_g, pix_b});
        end else begin
          e = exp_q.pop_front();
          if ({pix_index, pix_r, pix_g, pix_b} !== e) begin
            n_err++;
            $display("FAIL pixel: got %h want %h", {pix_index, pix_r, pix_g, pix_b}, e);
          end
        end
      end else if (pix_valid) begin
        hold_pend = 1'b1;
        hold_val  = {pix_valid, pix_index, pix_r, pix_g, pix_b};
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    int done_cnt;
    init_tab();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full stream with ready held high, timing checked cycle by cycle
    pix_ready = 1'b1;
    push_frame(0);
    frame_in = mk_frame(0);
    capture  = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    chk("t1_busy_after_cap", 32'(busy), 32'd1);
    chk("t1_valid_in_load", 32'(pix_valid), 32'd0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 16) begin
        chk("t1_valid", 32'(pix_valid), 32'd1);
        chk("t1_index", 32'(pix_index), 32'(cyc - 1));
      end
      chk("t1_done", 32'(frame_done), (cyc == 17) ? 32'd1 : 32'd0);
      if (cyc >= 17) chk("t1_busy_end", 32'(busy), 32'd0);
    end
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready pattern 1,0,0,1
    push_frame(3);
    frame_in = mk_frame(3);
    capture  = 1'b1;
    @(posedge clk); #1;
    capture  = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(posedge clk); #1;
      if (frame_done) done_cnt++;
      pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (done_cnt != 0) break;
    end
    chk("t2_done_seen", 32'(done_cnt), 32'd1);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    pix_ready = 1'b1;
    @(posedge clk); #1;

    // Capture pulses during stream are dropped and the snapshot stays intact
    push_frame(7);
    frame_in = mk_frame(7);
    capture  = 1'b1;
    @(posedge clk); #1;
    capture  = 1'b0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (frame_done) done_cnt++;
      capture  = (cyc == 3) || (cyc == 6) || (cyc == 9);
      frame_in = mk_frame((cyc % 2 != 0) ? 9 : 1);
    end
    capture = 1'b0;
    chk("t3_done_once", 32'(done_cnt), 32'd1);
    chk("t3_dropped", 32'(dropped), 32'd3);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with capture held high
    push_frame(0);
    push_frame(2);
    frame_in = mk_frame(0);
    capture  = 1'b1;
    @(posedge clk); #1;
    frame_in = mk_frame(2);
    wait_done("t4_done1", 40);
    chk("t4_busy_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("t4_busy_rearm", 32'(busy), 32'd1);
    chk("t4_valid_load", 32'(pix_valid), 32'd0);
    capture = 1'b0;
    @(posedge clk); #1;
    chk("t4_valid_lane0", 32'(pix_valid), 32'd1);
    chk("t4_index_lane0", 32'(pix_index), 32'd0);
    wait_done("t4_done2", 40);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while lane 7 is presented
    push_frame(5);
    frame_in = mk_frame(5);
    capture  = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_index7", 32'(pix_index), 32'd7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    chk("t5_sb_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_frame(4);
    frame_in = mk_frame(4);
    capture  = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    @(posedge clk); #1;
    chk("t5_restart_index", 32'(pix_index), 32'd0);
    chk("t5_restart_valid", 32'(pix_valid), 32'd1);
    wait_done("t5_done", 40);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
